sl3_rx_burst_deframer: RTL



---
 rtl/sl3_rx_pkg.sv | 22 ++
 rtl/sl3_rx_fifo.sv | 53 +++++
 rtl/sl3_rx_burst_deframer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sl3_rx_pkg.sv
// rtl/sl3_rx_pkg.sv - shared types and constants for the SL3 RX burst deframer
package sl3_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST   = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam int ERR_SOB_IN_BURST = 0;
    localparam int ERR_OUTSIDE      = 1;
    localparam int ERR_OVERFLOW     = 2;
    localparam int ERR_LINK_DROP    = 3;

    // Marker part of a buffered entry; the full entry is {tag, data}.
    typedef struct packed {
        logic abort;
        logic last;
        logic first;
    } entry_tag_t;

endpackage

// File: rtl/sl3_rx_fifo.sv
// rtl/sl3_rx_fifo.sv - synchronous show-ahead FIFO with free-entry count
module sl3_rx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          valid,
    output logic          full,
    output logic [AW:0]   free
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // Push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_pop   = pop && (count != '0);
    assign do_push  = push && (!full || do_pop);
    assign valid    = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign free     = (AW+1)'(DEPTH) - count;
    assign pop_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sl3_rx_burst_deframer.sv
// rtl/sl3_rx_burst_deframer.sv - SL3 RX burst framing checker and buffer (optional SL3_RX_BURST_STATS_EN)
module sl3_rx_burst_deframer
    import sl3_rx_pkg::*;
#(
    parameter int DATA_W        = 256,
    parameter int FIFO_DEPTH    = 8,
    parameter int READY_LATENCY = 2
) (
    input  logic              interface_clock_rx,
    input  logic              interface_clock_reset_rx_n,
    input  logic [DATA_W-1:0] data_rx,
    input  logic              valid_rx,
    input  logic              start_of_burst_rx,
    input  logic              end_of_burst_rx,
    input  logic              link_up_rx,
    output logic              ready_rx,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_first,
    output logic              out_last,
    output logic              out_abort,
    output logic [3:0]        err_sticky,
    input  logic              err_clear
`ifdef SL3_RX_BURST_STATS_EN
    ,
    output logic [31:0]       burst_count,
    output logic [31:0]       beat_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    state_t            state;
    state_t            state_n;
    logic              pending_term;
    logic              pending_n;
    logic              pend_set;
    logic              pend_clr;
    logic              real_push;
    logic              term_push;
    logic              push;
    logic              pop;
    logic              can_accept;
    logic              full;
    logic [AW:0]       free;
    logic [3:0]        err_set;
    entry_tag_t        tag;
    logic [DATA_W-1:0] push_dat;
    entry_tag_t        head_tag;
    logic              ready_n;

    sl3_rx_fifo #(
        .W     (DATA_W + 3),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (interface_clock_rx),
        .resetn    (interface_clock_reset_rx_n),
        .push      (push),
        .push_data ({tag, push_dat}),
        .pop       (pop),
        .pop_data  ({head_tag, out_data}),
        .valid     (out_valid),
        .full      (full),
        .free      (free)
    );

    assign pop        = out_valid && out_ready;
    assign can_accept = !full || pop;
    assign out_first  = out_valid && head_tag.first;
    assign out_last   = out_valid && head_tag.last;
    assign out_abort  = out_valid && head_tag.abort;

    // Framing FSM: classifies each beat, decides push/drop, errors and terminator insertion.
    always_comb begin
        state_n   = state;
        real_push = 1'b0;
        tag       = '0;
        push_dat  = data_rx;
        pend_set  = 1'b0;
        pend_clr  = 1'b0;
        err_set   = '0;
        if (!link_up_rx) begin
            // Beats are ignored while the link is down; any open burst is cut.
            if (state == BURST) err_set[ERR_LINK_DROP] = 1'b1;
            if (state != IDLE) begin
                state_n  = IDLE;
                pend_set = 1'b1;
            end
        end else if (valid_rx) begin
            unique case (state)
                IDLE: begin
                    if (!start_of_burst_rx) begin
                        err_set[ERR_OUTSIDE] = 1'b1;
                    end else if (can_accept) begin
                        real_push = 1'b1;
                        tag.first = 1'b1;
                        tag.last  = end_of_burst_rx;
                        tag.abort = pending_term;
                        pend_clr  = 1'b1;
                        state_n   = end_of_burst_rx ? IDLE : BURST;
                    end else begin
                        err_set[ERR_OVERFLOW] = 1'b1;
                        if (!end_of_burst_rx) begin
                            state_n  = DISCARD;
                            pend_set = 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (start_of_burst_rx) err_set[ERR_SOB_IN_BURST] = 1'b1;
                    if (can_accept) begin
                        real_push = 1'b1;
                        tag.first = start_of_burst_rx;
                        tag.abort = start_of_burst_rx;
                        tag.last  = end_of_burst_rx;
                        if (end_of_burst_rx) state_n = IDLE;
                    end else begin
                        err_set[ERR_OVERFLOW] = 1'b1;
                        state_n  = DISCARD;
                        pend_set = 1'b1;
                    end
                end
                DISCARD: begin
                    if (end_of_burst_rx) state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
        // A terminator fills the first free slot not claimed by a real beat.
        term_push = pending_term && !real_push && can_accept;
        if (term_push) begin
            tag       = '{abort: 1'b1, last: 1'b1, first: 1'b0};
            push_dat  = '0;
        end
        push      = real_push || term_push;
        pending_n = pend_set || (pending_term && !pend_clr && !term_push);
        ready_n   = link_up_rx &&
                    ((int'(free) - int'(push) + int'(pop)) > READY_LATENCY);
    end

    // State, pending terminator and registered backpressure.
    always_ff @(posedge interface_clock_rx) begin
        if (!interface_clock_reset_rx_n) begin
            state        <= IDLE;
            pending_term <= 1'b0;
            ready_rx     <= 1'b0;
        end else begin
            state        <= state_n;
            pending_term <= pending_n;
            ready_rx     <= ready_n;
        end
    end

    // Sticky errors; a fresh error in the clearing cycle survives the clear.
    always_ff @(posedge interface_clock_rx) begin
        if (!interface_clock_reset_rx_n) begin
            err_sticky <= '0;
        end else begin
            err_sticky <= (err_clear ? 4'b0000 : err_sticky) | err_set;
        end
    end

`ifdef SL3_RX_BURST_STATS_EN
    // Completed-burst and real-beat counters; terminators are not counted.
    always_ff @(posedge interface_clock_rx) begin
        if (!interface_clock_reset_rx_n) begin
            burst_count <= '0;
            beat_count  <= '0;
        end else begin
            if (real_push && tag.last && !tag.abort) burst_count <= burst_count + 32'd1;
            if (real_push) beat_count <= beat_count + 32'd1;
        end
    end
`endif

endmodule
